key_sw_filter: RTL and testbench

KEY_SW_FILTER -- requirements
Module: key_sw_filter

---
 rtl/key_sw_filter.sv | 147 ++++++++++++++
 tb/tb_key_sw_filter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_sw_filter.sv
// Debounce and edge/auto-repeat pulse generator for N key/switch inputs.
// A shared prescaler tick paces sampling; each channel filters, detects edges and repeats on its own.
module key_sw_filter #(
  parameter int N          = 12,
  parameter int DIV        = 1250000,
  parameter int STABLE     = 3,
  parameter int ACTIVE_LOW = 1,
  parameter int REP_DLY    = 20,
  parameter int REP_INT    = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] IN,
  input  logic [1:0]   EDGE_SEL,
  input  logic [N-1:0] REP_EN,
  output logic [N-1:0] LEVEL,
  output logic [N-1:0] PULSE,
  output logic         TICK
);

  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW   = $clog2(STABLE + 1);
  localparam int RMAX = (REP_DLY > REP_INT) ? REP_DLY : REP_INT;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic          IDLE_LVL  = (ACTIVE_LOW != 0);
  localparam logic [PW-1:0] DIV_M1    = PW'(DIV - 1);
  localparam logic [PW-1:0] DIV_M2    = PW'(DIV - 2);
  localparam logic [SW-1:0] STABLE_M1 = SW'(STABLE - 1);
  localparam logic [RW-1:0] DLY_C     = RW'(REP_DLY);
  localparam logic [RW-1:0] INT_C     = RW'(REP_INT);

  typedef enum logic [1:0] {R_IDLE, R_HOLD, R_RPT} rpt_t;

  logic [PW-1:0] presc_reg;
  logic          tick_reg;
  logic [N-1:0]  sync1_reg;
  logic [N-1:0]  sync2_reg;

  // TICK is registered one cycle early so it is high exactly while presc_reg == DIV-1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      presc_reg <= (presc_reg == DIV_M1) ? '0 : presc_reg + 1'b1;
      tick_reg  <= (presc_reg == DIV_M2);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_reg <= {N{IDLE_LVL}};
      sync2_reg <= {N{IDLE_LVL}};
    end else begin
      sync1_reg <= IN;
      sync2_reg <= sync1_reg;
    end
  end

  assign TICK = tick_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic [SW-1:0] stab_reg;
    logic [RW-1:0] rcnt_reg;
    rpt_t          st_reg;
    logic          level_reg;
    logic          pulse_reg;
    logic          differ;
    logic          accept;
    logic          press_acc;
    logic          rel_acc;
    logic          edge_hit;
    logic [RW-1:0] rcnt_nx;

    assign differ    = sync2_reg[gi] ^ level_reg;
    assign accept    = tick_reg && differ && (stab_reg == STABLE_M1);
    assign press_acc = accept && (sync2_reg[gi] != IDLE_LVL);
    assign rel_acc   = accept && (sync2_reg[gi] == IDLE_LVL);
    assign edge_hit  = (press_acc && (EDGE_SEL == 2'b00)) ||
                       (rel_acc   && (EDGE_SEL == 2'b01)) ||
                       (accept    && (EDGE_SEL == 2'b10));
    assign rcnt_nx   = rcnt_reg + 1'b1;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        stab_reg  <= '0;
        rcnt_reg  <= '0;
        st_reg    <= R_IDLE;
        level_reg <= IDLE_LVL;
        pulse_reg <= 1'b0;
      end else begin
        pulse_reg <= edge_hit;
        if (tick_reg) begin
          stab_reg <= (differ && !accept) ? stab_reg + 1'b1 : '0;
        end
        if (accept) begin
          level_reg <= sync2_reg[gi];
        end
        // A release always lands in IDLE, so its edge pulse can never meet a repeat pulse.
        case (st_reg)
          R_IDLE: begin
            if (press_acc && REP_EN[gi]) begin
              st_reg   <= R_HOLD;
              rcnt_reg <= '0;
            end
          end
          R_HOLD: begin
            if (rel_acc || !REP_EN[gi]) begin
              st_reg   <= R_IDLE;
              rcnt_reg <= '0;
            end else if (tick_reg) begin
              if (rcnt_nx == DLY_C) begin
                pulse_reg <= 1'b1;
                rcnt_reg  <= '0;
                st_reg    <= R_RPT;
              end else begin
                rcnt_reg <= rcnt_nx;
              end
            end
          end
          R_RPT: begin
            if (rel_acc || !REP_EN[gi]) begin
              st_reg   <= R_IDLE;
              rcnt_reg <= '0;
            end else if (tick_reg) begin
              if (rcnt_nx == INT_C) begin
                pulse_reg <= 1'b1;
                rcnt_reg  <= '0;
              end else begin
                rcnt_reg <= rcnt_nx;
              end
            end
          end
          default: begin
            st_reg   <= R_IDLE;
            rcnt_reg <= '0;
          end
        endcase
      end
    end

    assign LEVEL[gi] = level_reg;
    assign PULSE[gi] = pulse_reg;
  end

endmodule

// File: tb/tb_key_sw_filter.sv
// Directed bench for key_sw_filter with N=4, DIV=4, STABLE=3, REP_DLY=3, REP_INT=2.
module tb_key_sw_filter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] IN;
  logic [1:0] EDGE_SEL;
  logic [3:0] REP_EN;
  logic [3:0] LEVEL;
  logic [3:0] PULSE;
  logic       TICK;

  key_sw_filter #(
    .N(4), .DIV(4), .STABLE(3), .ACTIVE_LOW(1), .REP_DLY(3), .REP_INT(2)
  ) dut (
    .CLK(CLK), .RST(RST), .IN(IN), .EDGE_SEL(EDGE_SEL), .REP_EN(REP_EN),
    .LEVEL(LEVEL), .PULSE(PULSE), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Pulse log per channel: count and cycle stamp of each strobe.
  int pcnt[4] = '{0, 0, 0, 0};
  int ptime[4][64];
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (PULSE[i] === 1'b1) begin
        if (pcnt[i] < 64) ptime[i][pcnt[i]] = cyc;
        pcnt[i]++;
      end
    end
  end

  int cmp = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Returns 1ns into the next cycle where TICK is high.
  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(posedge CLK);
      #1;
      k++;
    end while (TICK !== 1'b1 && k < 20);
    chk("tick_wait", {31'b0, TICK}, 32'd1);
  endtask

  function automatic int psum();
    return pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3];
  endfunction

  initial begin
    int t0;
    int base;
    RST = 1'b0;
    IN = 4'hF;
    EDGE_SEL = 2'b00;
    REP_EN = 4'h0;
    step(3);
    chk("rst_level", {28'b0, LEVEL}, 32'hF);
    chk("rst_pulse", {28'b0, PULSE}, 32'h0);
    chk("rst_tick", {31'b0, TICK}, 32'h0);
    RST = 1'b1;

    // Prescaler period and single-cycle tick
    wait_tick();
    t0 = cyc;
    wait_tick();
    chk("tick_period", cyc - t0, 32'd4);
    step(1);
    chk("tick_width", {31'b0, TICK}, 32'd0);

    // Press on channel 0: accepted at the 3rd tick after sync, single press pulse
    wait_tick();
    IN[0] = 1'b0;
    repeat (3) wait_tick();
    chk("press0_before", {31'b0, LEVEL[0]}, 32'd1);
    step(1);
    chk("press0_level", {28'b0, LEVEL}, 32'hE);
    chk("press0_pulse", {28'b0, PULSE}, 32'h1);
    step(1);
    chk("press0_pulse_end", {28'b0, PULSE}, 32'h0);
    base = pcnt[0];
    IN[0] = 1'b1;
    repeat (5) wait_tick();
    chk("release0_level", {28'b0, LEVEL}, 32'hF);
    chk("release0_nopulse", pcnt[0] - base, 32'd0);

    // Two-tick glitch on channel 1 must be rejected
    EDGE_SEL = 2'b10;
    base = pcnt[1];
    wait_tick();
    IN[1] = 1'b0;
    repeat (2) wait_tick();
    IN[1] = 1'b1;
    repeat (4) wait_tick();
    chk("glitch1_level", {28'b0, LEVEL}, 32'hF);
    chk("glitch1_nopulse", pcnt[1] - base, 32'd0);

    // Auto-repeat on channel 2: press, +3 ticks, then every 2 ticks until release
    EDGE_SEL = 2'b00;
    REP_EN = 4'b0100;
    base = pcnt[2];
    wait_tick();
    IN[2] = 1'b0;
    repeat (12) wait_tick();
    IN[2] = 1'b1;
    repeat (6) wait_tick();
    chk("rep2_count", pcnt[2] - base, 32'd6);
    chk("rep2_first_gap", ptime[2][base+1] - ptime[2][base], 32'd12);
    for (int k = 2; k < 6; k++)
      chk("rep2_gap", ptime[2][base+k] - ptime[2][base+k-1], 32'd8);
    chk("rep2_level", {28'b0, LEVEL}, 32'hF);

    // Dropping REP_EN during HOLD cancels the pending repeat
    base = pcnt[2];
    wait_tick();
    IN[2] = 1'b0;
    repeat (4) wait_tick();
    REP_EN = 4'b0000;
    repeat (6) wait_tick();
    chk("repoff2_count", pcnt[2] - base, 32'd1);
    IN[2] = 1'b1;
    repeat (5) wait_tick();

    // Edge select modes on channel 3: both, release only, none
    EDGE_SEL = 2'b10;
    base = pcnt[3];
    wait_tick();
    IN[3] = 1'b0;
    repeat (5) wait_tick();
    IN[3] = 1'b1;
    repeat (5) wait_tick();
    chk("both3_count", pcnt[3] - base, 32'd2);

    EDGE_SEL = 2'b01;
    base = pcnt[3];
    IN[3] = 1'b0;
    repeat (5) wait_tick();
    chk("rel3_press_none", pcnt[3] - base, 32'd0);
    EDGE_SEL = 2'b00;
    step(3);
    EDGE_SEL = 2'b01;
    chk("rel3_selchange_none", pcnt[3] - base, 32'd0);
    IN[3] = 1'b1;
    repeat (5) wait_tick();
    chk("rel3_count", pcnt[3] - base, 32'd1);

    EDGE_SEL = 2'b11;
    base = pcnt[3];
    IN[3] = 1'b0;
    repeat (5) wait_tick();
    chk("none3_level", {28'b0, LEVEL}, 32'h7);
    IN[3] = 1'b1;
    repeat (5) wait_tick();
    chk("none3_count", pcnt[3] - base, 32'd0);

    // Simultaneous press on channels 0 and 1
    EDGE_SEL = 2'b00;
    wait_tick();
    IN[1:0] = 2'b00;
    repeat (3) wait_tick();
    step(1);
    chk("simul_pulse", {28'b0, PULSE}, 32'h3);
    chk("simul_level", {28'b0, LEVEL}, 32'hC);
    IN = 4'hF;
    repeat (5) wait_tick();

    // Reset in the middle of HOLD on channel 2
    REP_EN = 4'b0100;
    wait_tick();
    IN[2] = 1'b0;
    repeat (4) wait_tick();
    chk("hold2_level", {28'b0, LEVEL}, 32'hB);
    RST = 1'b0;
    #1;
    chk("midrst_level", {28'b0, LEVEL}, 32'hF);
    chk("midrst_pulse", {28'b0, PULSE}, 32'h0);
    chk("midrst_tick", {31'b0, TICK}, 32'd0);
    IN = 4'hF;
    step(3);
    base = psum();
    RST = 1'b1;
    repeat (20) wait_tick();
    chk("postrst_nopulse", psum() - base, 32'd0);
    chk("postrst_level", {28'b0, LEVEL}, 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
